// File: rtl/actor_trigger_pkg.sv
// Types shared by every trigger flavour: HLS actor return codes, the trigger
// FSM state encoding, the trigger flavour tag and the sleep timer width.
package TriggerTypes;

   localparam int TRIGGER_TIMER_W = 8;

   typedef enum logic [31:0] {
      RET_IDLE        = 32'd0,
      RET_WAIT_INPUT  = 32'd1,
      RET_WAIT_OUTPUT = 32'd2,
      RET_WAIT_INOUT  = 32'd3,
      RET_EXECUTED    = 32'd4
   } return_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_CHECK,
      ST_SLEEP,
      ST_SYNC_LAUNCH,
      ST_SYNC_CHECK,
      ST_SYNC_EXEC,
      ST_SYNC_WAIT
   } state_t;

   typedef enum logic [1:0] {
      MODE_ACTOR_TRIGGER,
      MODE_CYCLE_TRIGGER,
      MODE_STATIC_TRIGGER
   } mode_t;

   // Only an explicit EXECUTED counts as progress; every other code stalls.
   function automatic logic made_progress(input logic [31:0] ret);
      return ret == RET_EXECUTED;
   endfunction

endpackage

// File: rtl/actor_trigger.sv
// Per-actor launch controller (ACTOR_TRIGGER flavour): relaunches the actor,
// sleeps on stalls and joins the network-wide sleep/sync termination round.
module actor_trigger
   import TriggerTypes::*;
#(
   parameter int SLEEP_CYCLES = 15
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        ap_start,
   output logic        ap_done,
   output logic        ap_idle,
   output logic        ap_ready,
   output logic        actor_start,
   input  logic        actor_ready,
   input  logic        actor_done,
   input  logic        actor_idle,
   input  logic [31:0] actor_return,
   input  logic        all_sleep,
   input  logic        all_sync,
   input  logic        all_sync_wait,
   output logic        sleep,
   output logic        sync_wait,
   output logic        sync_exec
);

   localparam logic [TRIGGER_TIMER_W-1:0] SLEEP_LOAD = TRIGGER_TIMER_W'(SLEEP_CYCLES - 1);

   state_t                     state;
   logic [TRIGGER_TIMER_W-1:0] timer;
   logic [31:0]                last_ret;

   // actor_start is raised on every entry into a launch state and held until
   // the actor accepts it; ap_done is a one-cycle pulse on termination.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state       <= ST_IDLE;
         timer       <= '0;
         last_ret    <= RET_IDLE;
         actor_start <= 1'b0;
         ap_done     <= 1'b0;
      end else begin
         ap_done <= 1'b0;
         if (actor_done) begin
            last_ret <= actor_return;
         end
         case (state)
            ST_IDLE: begin
               if (ap_start) begin
                  state       <= ST_LAUNCH;
                  actor_start <= 1'b1;
               end
            end
            ST_LAUNCH, ST_SYNC_LAUNCH: begin
               if (actor_ready) begin
                  actor_start <= 1'b0;
               end
               if (actor_done) begin
                  state <= (state == ST_LAUNCH) ? ST_CHECK : ST_SYNC_CHECK;
               end
            end
            ST_CHECK: begin
               if (made_progress(last_ret)) begin
                  state       <= ST_LAUNCH;
                  actor_start <= 1'b1;
               end else begin
                  state <= ST_SLEEP;
                  timer <= SLEEP_LOAD;
               end
            end
            // A network-wide sleep outranks the local retry timer.
            ST_SLEEP: begin
               if (all_sleep) begin
                  state       <= ST_SYNC_LAUNCH;
                  actor_start <= 1'b1;
               end else if (timer == '0) begin
                  state       <= ST_LAUNCH;
                  actor_start <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            ST_SYNC_CHECK: begin
               state <= made_progress(last_ret) ? ST_SYNC_EXEC : ST_SYNC_WAIT;
            end
            ST_SYNC_EXEC: begin
               if (all_sync) begin
                  state       <= ST_LAUNCH;
                  actor_start <= 1'b1;
               end
            end
            // Termination wins when everyone stalled in the same round.
            ST_SYNC_WAIT: begin
               if (all_sync_wait) begin
                  state   <= ST_IDLE;
                  ap_done <= 1'b1;
               end else if (all_sync) begin
                  state       <= ST_LAUNCH;
                  actor_start <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               actor_start <= 1'b0;
            end
         endcase
      end
   end

   assign ap_ready  = ap_done;
   assign ap_idle   = (state == ST_IDLE);
   assign sleep     = (state == ST_SLEEP);
   assign sync_wait = (state == ST_SYNC_WAIT);
   assign sync_exec = (state == ST_SYNC_EXEC);

   // The actor must complete in the same cycle it reports ready, while busy.
   a_done_with_ready : assert property (@(posedge ap_clk) disable iff (ap_rst)
      actor_done |-> actor_ready);
   a_done_while_busy : assert property (@(posedge ap_clk) disable iff (ap_rst)
      actor_done |-> !actor_idle);
   a_start_in_launch : assert property (@(posedge ap_clk) disable iff (ap_rst)
      actor_start |-> (state == ST_LAUNCH || state == ST_SYNC_LAUNCH));
   a_timer_bounded   : assert property (@(posedge ap_clk) disable iff (ap_rst)
      timer <= SLEEP_LOAD);

endmodule

// File: tb/tb_actor_trigger.sv
// Randomized self-checking bench for actor_trigger: two instances (long and
// short sleep) share stimulus; expectations come from cycle-count arithmetic.
module tb_actor_trigger;
   import TriggerTypes::*;

   localparam int LONG_SLEEP  = 15;
   localparam int SHORT_SLEEP = 4;
   localparam int WAIT_BOUND  = 300;

   logic        ap_clk = 1'b0;
   logic        ap_rst, ap_start;
   logic        actor_ready, actor_done, actor_idle;
   logic [31:0] actor_return;
   logic        all_sleep, all_sync, all_sync_wait;

   logic ap_done, ap_idle, ap_ready, actor_start, sleep, sync_wait, sync_exec;
   logic ap_done_s, ap_idle_s, ap_ready_s, actor_start_s, sleep_s, sync_wait_s, sync_exec_s;

   int checks = 0;
   int errors = 0;

   always #5 ap_clk = ~ap_clk;

   actor_trigger #(.SLEEP_CYCLES(LONG_SLEEP)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .actor_start(actor_start), .actor_ready(actor_ready), .actor_done(actor_done),
      .actor_idle(actor_idle), .actor_return(actor_return),
      .all_sleep(all_sleep), .all_sync(all_sync), .all_sync_wait(all_sync_wait),
      .sleep(sleep), .sync_wait(sync_wait), .sync_exec(sync_exec)
   );

   actor_trigger #(.SLEEP_CYCLES(SHORT_SLEEP)) dut_s (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done_s), .ap_idle(ap_idle_s), .ap_ready(ap_ready_s),
      .actor_start(actor_start_s), .actor_ready(actor_ready), .actor_done(actor_done),
      .actor_idle(actor_idle), .actor_return(actor_return),
      .all_sleep(all_sleep), .all_sync(all_sync), .all_sync_wait(all_sync_wait),
      .sleep(sleep_s), .sync_wait(sync_wait_s), .sync_exec(sync_exec_s)
   );

   // Reference rules: only EXECUTED is progress; a stall costs CHECK plus a
   // full sleep, progress costs only the CHECK cycle.
   function automatic bit is_progress(input logic [31:0] r);
      return r == 32'd4;
   endfunction

   function automatic int expected_gap(input logic [31:0] r, input int sleep_len);
      return is_progress(r) ? 2 : sleep_len + 2;
   endfunction

   function automatic logic [31:0] rand_stall_code();
      int pick;
      pick = $urandom_range(0, 4);
      case (pick)
         0:       return RET_IDLE;
         1:       return RET_WAIT_INPUT;
         2:       return RET_WAIT_OUTPUT;
         3:       return RET_WAIT_INOUT;
         default: return 32'd5 + 32'($urandom_range(0, 100000));
      endcase
   endfunction

   function automatic logic start_of(input bit s);
      return s ? actor_start_s : actor_start;
   endfunction

   function automatic logic sleep_of(input bit s);
      return s ? sleep_s : sleep;
   endfunction

   // {ap_done, ap_ready, ap_idle, actor_start, sleep, sync_wait, sync_exec}
   function automatic logic [6:0] outs_of(input bit s);
      if (s) return {ap_done_s, ap_ready_s, ap_idle_s, actor_start_s, sleep_s, sync_wait_s, sync_exec_s};
      return {ap_done, ap_ready, ap_idle, actor_start, sleep, sync_wait, sync_exec};
   endfunction

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_reset();
      ap_rst        = 1'b1;
      ap_start      = 1'b0;
      actor_ready   = 1'b0;
      actor_done    = 1'b0;
      actor_idle    = 1'b1;
      actor_return  = 32'd0;
      all_sleep     = 1'b0;
      all_sync      = 1'b0;
      all_sync_wait = 1'b0;
      step();
      step();
      ap_rst = 1'b0;
   endtask

   // Behaves as the HLS actor: called while actor_start is visibly high,
   // answers ready+done in cycle 'delay' and reports how long start stayed up.
   task automatic serve(input bit s, input int delay, input logic [31:0] ret, output int hi);
      hi = 0;
      actor_idle = 1'b0;
      for (int i = 0; i <= delay; i++) begin
         if (start_of(s)) hi++;
         if (i == delay) begin
            actor_ready  = 1'b1;
            actor_done   = 1'b1;
            actor_return = ret;
         end
         step();
      end
      if (start_of(s)) hi++;
      actor_ready  = 1'b0;
      actor_done   = 1'b0;
      actor_idle   = 1'b1;
      actor_return = $urandom;
   endtask

   task automatic wait_start(input bit s, output int steps, output int sleeps);
      steps  = 0;
      sleeps = 0;
      do begin
         step();
         steps++;
         if (sleep_of(s)) sleeps++;
      end while (!start_of(s) && steps < WAIT_BOUND);
   endtask

   // Drives a fresh run into the sync round; leaves the first SYNC_* cycle visible.
   task automatic enter_sync(input logic [31:0] sync_ret);
      int hi;
      do_reset();
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      serve(1'b0, $urandom_range(0, 3), rand_stall_code(), hi);
      step();
      all_sleep = 1'b1;
      step();
      all_sleep = 1'b0;
      serve(1'b0, $urandom_range(0, 3), sync_ret, hi);
      step();
   endtask

   task automatic test_reset();
      do_reset();
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (outs_of(s[0]) !== 7'b0010000) begin
            errors++;
            $display("[TB] FAIL reset_outputs dut%0d: got %b, want %b", s, outs_of(s[0]), 7'b0010000);
         end
      end
      step();
      checks++;
      if (outs_of(1'b0) !== 7'b0010000) begin
         errors++;
         $display("[TB] FAIL idle_hold: got %b, want %b", outs_of(1'b0), 7'b0010000);
      end
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      checks++;
      if ({actor_start, ap_idle, actor_start_s, ap_idle_s} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL start_latency: got %b, want 1010", {actor_start, ap_idle, actor_start_s, ap_idle_s});
      end
   endtask

   task automatic test_launch_loop();
      int hi, steps, sleeps, nexec, delay;
      logic [31:0] ret;
      do_reset();
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      for (int round = 0; round < 4; round++) begin
         nexec = (round == 0) ? 3 : $urandom_range(0, 3);
         for (int k = 0; k <= nexec; k++) begin
            if (k < nexec) ret = RET_EXECUTED;
            else ret = (round == 0) ? 32'(RET_WAIT_INPUT) : rand_stall_code();
            delay = $urandom_range(0, 4);
            ap_start = 1'($urandom_range(0, 1));
            serve(1'b0, delay, ret, hi);
            checks++;
            if (hi !== delay + 1) begin
               errors++;
               $display("[TB] FAIL launch_width: got %0d cycles, want %0d", hi, delay + 1);
            end
            wait_start(1'b0, steps, sleeps);
            checks++;
            if (steps + 1 !== expected_gap(ret, LONG_SLEEP) || sleeps !== (is_progress(ret) ? 0 : LONG_SLEEP)) begin
               errors++;
               $display("[TB] FAIL relaunch ret=%0h: got gap %0d sleep %0d, want gap %0d sleep %0d",
                        ret, steps + 1, sleeps, expected_gap(ret, LONG_SLEEP), is_progress(ret) ? 0 : LONG_SLEEP);
            end
         end
      end
      ap_start = 1'b0;
   endtask

   task automatic test_sleep_preempt();
      int hi, k;
      for (int t = 0; t < 3; t++) begin
         k = (t == 0) ? 2 : (t == 1) ? SHORT_SLEEP : $urandom_range(1, SHORT_SLEEP);
         do_reset();
         ap_start = 1'b1;
         step();
         ap_start = 1'b0;
         serve(1'b1, $urandom_range(0, 3), RET_WAIT_OUTPUT, hi);
         step();
         for (int c = 1; c < k; c++) step();
         checks++;
         if (sleep_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sleep_cycle_%0d: got sleep %b, want 1", k, sleep_s);
         end
         all_sleep = 1'b1;
         step();
         all_sleep = 1'b0;
         checks++;
         if ({actor_start_s, sleep_s} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL preempt_k%0d: got start,sleep %b, want 10", k, {actor_start_s, sleep_s});
         end
         serve(1'b1, $urandom_range(0, 3), RET_WAIT_INPUT, hi);
         step();
         checks++;
         if ({sync_wait_s, sync_exec_s, actor_start_s} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL preempt_is_sync_k%0d: got wait,exec,start %b, want 100", k,
                     {sync_wait_s, sync_exec_s, actor_start_s});
         end
      end
   endtask

   task automatic test_sync_terminate();
      int w, hi;
      for (int t = 0; t < 3; t++) begin
         w = (t == 0) ? 3 : $urandom_range(1, 6);
         enter_sync(rand_stall_code());
         hi = 0;
         for (int i = 1; i <= w; i++) begin
            if (sync_wait === 1'b1 && ap_done === 1'b0) hi++;
            if (i == w) begin
               all_sync_wait = 1'b1;
               all_sync      = 1'b1;
            end
            step();
         end
         all_sync_wait = 1'b0;
         all_sync      = 1'b0;
         checks++;
         if (hi !== w) begin
            errors++;
            $display("[TB] FAIL sync_wait_len: got %0d cycles, want %0d", hi, w);
         end
         checks++;
         if ({ap_done, ap_ready, ap_idle, sync_wait, actor_start} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL done_pulse: got %b, want 11100", {ap_done, ap_ready, ap_idle, sync_wait, actor_start});
         end
         step();
         checks++;
         if ({ap_done, ap_ready, ap_idle} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL done_width: got %b, want 001", {ap_done, ap_ready, ap_idle});
         end
      end
   endtask

   task automatic test_sync_exec();
      int x, hi;
      bit seen_done;
      for (int t = 0; t < 3; t++) begin
         x = (t == 0) ? 5 : $urandom_range(1, 6);
         enter_sync(RET_EXECUTED);
         hi = 0;
         seen_done = 1'b0;
         for (int i = 1; i <= x; i++) begin
            if (sync_exec === 1'b1) hi++;
            if (ap_done !== 1'b0) seen_done = 1'b1;
            if (i == x) all_sync = 1'b1;
            step();
         end
         all_sync = 1'b0;
         checks++;
         if (hi !== x || seen_done) begin
            errors++;
            $display("[TB] FAIL sync_exec_len: got %0d cycles done_seen %0d, want %0d done_seen 0", hi, seen_done, x);
         end
         checks++;
         if ({actor_start, sync_exec, ap_done, ap_idle} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL sync_exec_release: got %b, want 1000", {actor_start, sync_exec, ap_done, ap_idle});
         end
      end
      enter_sync(RET_WAIT_INOUT);
      step();
      all_sync = 1'b1;
      step();
      all_sync = 1'b0;
      checks++;
      if ({actor_start, sync_wait, ap_done, ap_idle} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL sync_wait_release: got %b, want 1000", {actor_start, sync_wait, ap_done, ap_idle});
      end
   endtask

   task automatic test_ready_delay();
      int hi, steps, sleeps;
      do_reset();
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      serve(1'b0, 7, RET_EXECUTED, hi);
      checks++;
      if (hi !== 8) begin
         errors++;
         $display("[TB] FAIL ready_delay_width: got %0d cycles, want 8", hi);
      end
      checks++;
      if (outs_of(1'b0) !== 7'b0000000) begin
         errors++;
         $display("[TB] FAIL check_cycle: got %b, want 0000000", outs_of(1'b0));
      end
      wait_start(1'b0, steps, sleeps);
      checks++;
      if (steps + 1 !== 2 || sleeps !== 0) begin
         errors++;
         $display("[TB] FAIL ready_delay_relaunch: got gap %0d sleep %0d, want gap 2 sleep 0", steps + 1, sleeps);
      end
   endtask

   task automatic test_reset_mid();
      int hi, steps, sleeps;
      do_reset();
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      ap_rst = 1'b1;
      step();
      checks++;
      if ({outs_of(1'b0), outs_of(1'b1)} !== {7'b0010000, 7'b0010000}) begin
         errors++;
         $display("[TB] FAIL reset_mid_launch: got %b %b, want 0010000", outs_of(1'b0), outs_of(1'b1));
      end
      ap_rst = 1'b0;
      step();
      checks++;
      if (outs_of(1'b0) !== 7'b0010000) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: got %b, want 0010000", outs_of(1'b0));
      end
      enter_sync(RET_WAIT_INPUT);
      step();
      checks++;
      if (sync_wait !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset_sync_wait: got %b, want 1", sync_wait);
      end
      ap_rst = 1'b1;
      step();
      checks++;
      if (outs_of(1'b0) !== 7'b0010000) begin
         errors++;
         $display("[TB] FAIL reset_mid_sync_wait: got %b, want 0010000", outs_of(1'b0));
      end
      ap_rst = 1'b0;
      do_reset();
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      serve(1'b0, $urandom_range(0, 3), 32'h0000_0009, hi);
      wait_start(1'b0, steps, sleeps);
      checks++;
      if (steps + 1 !== expected_gap(32'h9, LONG_SLEEP) || sleeps !== LONG_SLEEP) begin
         errors++;
         $display("[TB] FAIL undefined_code: got gap %0d sleep %0d, want gap %0d sleep %0d",
                  steps + 1, sleeps, expected_gap(32'h9, LONG_SLEEP), LONG_SLEEP);
      end
   endtask

   initial begin
      test_reset();
      test_launch_loop();
      test_sleep_preempt();
      test_sync_terminate();
      test_sync_exec();
      test_ready_delay();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: still running at %0t, want finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
